data_mem_responder: RTL

- Responder end of the MEM-stage data-memory interface: consumes the read/write enables, address, byte-lane select and store data driven from MEM.
- Returns load data with a one-cycle ready pulse after a programmable number of wait states.
- Holds a word-organised synchronous RAM.
- Sits beside the CPU top, opposite the EX_MEM/MEM stage; this is the block the MEM stage stalls against.

---
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Responder side of the MEM-stage data-memory port: word-organised RAM with byte lanes,
// programmable wait states, and a one-cycle ready/error completion pulse.
module data_mem_responder #(
  parameter int WORD_ADDR_WIDTH = 10,
  parameter int WAIT_CYCLES     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_memReadEnable,
  input  logic        i_memWriteEnable,
  input  logic [31:0] i_memAddr,
  input  logic [3:0]  i_memSel,
  input  logic [31:0] i_memWriteValue,
  output logic [31:0] o_memReadValue,
  output logic        o_ready,
  output logic        o_error,
  output logic        o_busy
);

  localparam int DEPTH = 1 << WORD_ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("data_mem_responder: WAIT_CYCLES must be within 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [WORD_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]                 sel_q, sel_d;
  logic [31:0]                wdata_q, wdata_d;
  logic                       op_write_q, op_write_d;
  logic                       req_err_q, req_err_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       ready_q, ready_d;
  logic                       error_q, error_d;
  logic                       busy_q, busy_d;

  logic [31:0] mem_q [DEPTH];

  logic        accept_s;
  logic        access_s;
  logic        mem_we_s;
  logic [31:0] addr_hi_s;

  // Expand a 4-bit lane select into a 32-bit byte mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int n = 0; n < 4; n++) begin
      m[8*n +: 8] = {8{sel[n]}};
    end
    return m;
  endfunction

  assign addr_hi_s = i_memAddr >> (WORD_ADDR_WIDTH + 2);
  assign accept_s  = (state_q == S_IDLE) && (i_memReadEnable || i_memWriteEnable);
  assign access_s  = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we_s  = access_s && op_write_q && !req_err_q && !rst;

  // State and registered-output update; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      sel_q      <= 4'd0;
      wdata_q    <= 32'd0;
      op_write_q <= 1'b0;
      req_err_q  <= 1'b0;
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
      req_err_q  <= req_err_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_WAIT;
        else          state_d = S_IDLE;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               state_d = S_WAIT;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, wait counting and next values of the registered outputs.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    op_write_d = op_write_q;
    req_err_d  = req_err_q;
    rdata_d    = 32'd0;
    ready_d    = 1'b0;
    error_d    = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cnt_d      = WAIT_INIT;
          idx_d      = i_memAddr[WORD_ADDR_WIDTH+1:2];
          sel_d      = i_memSel;
          wdata_d    = i_memWriteValue;
          op_write_d = i_memWriteEnable;
          req_err_d  = (i_memReadEnable && i_memWriteEnable) || (addr_hi_s != 32'd0);
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end
      S_WAIT: begin
        busy_d = 1'b1;
        if (access_s) begin
          ready_d = 1'b1;
          error_d = req_err_q;
          if (!req_err_q && !op_write_q) rdata_d = mem_q[idx_q] & lane_mask(sel_q);
          else                           rdata_d = 32'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_RESP:  busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // Byte-lane store; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_q[n]) mem_q[idx_q][8*n +: 8] <= wdata_q[8*n +: 8];
      end
    end
  end

  assign o_memReadValue = rdata_q;
  assign o_ready        = ready_q;
  assign o_error        = error_q;
  assign o_busy         = busy_q;

endmodule
